// File: rtl/feeder_pkg.sv
// Types and widths shared by the byte stream feeder, its FIFO and the downstream ring buffer.
// RING_SLOTS and SLOT_W must stay in step with the ring buffer's addr_ptr.
package feeder_pkg;

   localparam int unsigned RING_SLOTS = 16;
   localparam int unsigned SLOT_W     = 4;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned LEVEL_W    = 5;
   localparam int unsigned CNT_W      = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2
   } feeder_state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with a combinational head and an explicit occupancy counter.
// Pointers wrap modulo DEPTH (a power of two); level is kept separately from the pointers.
module sync_byte_fifo
   import feeder_pkg::*;
#(
   parameter int unsigned DEPTH = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [DATA_W-1:0]  wdata,
   output logic [DATA_W-1:0]  rdata,
   output logic [LEVEL_W-1:0] level,
   output logic               full,
   output logic               empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [AW-1:0]      r_wptr;
   logic [AW-1:0]      r_rptr;
   logic [LEVEL_W-1:0] r_level;
   logic               w_push;
   logic               w_pop;

   assign full  = (r_level == LEVEL_W'(DEPTH));
   assign empty = (r_level == '0);
   assign level = r_level;
   assign rdata = r_mem[r_rptr];

   // Guard against misuse so the counter can never leave 0..DEPTH.
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   // Storage is not reset: contents are meaningless once pointers and level clear.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LEVEL_W'(1);
            2'b01:   r_level <= r_level - LEVEL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/byte_stream_feeder.sv
// Turns a bursty valid/ready byte stream into one byte per enabled clock for the ring buffer,
// priming a FIFO before streaming and substituting FILL_BYTE on underrun.
module byte_stream_feeder
   import feeder_pkg::*;
#(
   parameter int unsigned      DEPTH     = 8,
   parameter int unsigned      PRIME_LVL = 4,
   parameter logic [DATA_W-1:0] FILL_BYTE = 8'h00
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [DATA_W-1:0]  data_out,
   output logic               data_valid,
   output logic [SLOT_W-1:0]  slot_idx,
   output logic [LEVEL_W-1:0] level,
   output logic [CNT_W-1:0]   underrun_cnt
);

   feeder_state_t      r_state;
   logic [DATA_W-1:0]  r_data_out;
   logic               r_data_valid;
   logic [SLOT_W-1:0]  r_slot_idx;
   logic [SLOT_W-1:0]  r_slot_ptr;
   logic [CNT_W-1:0]   r_underrun;

   logic               w_push;
   logic               w_pop;
   logic [DATA_W-1:0]  w_head;
   logic [LEVEL_W-1:0] w_level;
   logic               w_full;
   logic               w_empty;
   logic               w_primed;

   sync_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (in_data),
      .rdata (w_head),
      .level (w_level),
      .full  (w_full),
      .empty (w_empty)
   );

   // Ready depends on occupancy only, so a full FIFO stalls even when a pop is due.
   assign in_ready = !w_full;
   assign w_push   = in_valid && !w_full;
   assign w_pop    = (r_state == STREAM) && en && !w_empty;
   assign w_primed = (w_level >= LEVEL_W'(PRIME_LVL));

   // r_slot_ptr is the next ring slot; slot_idx is the slot of the byte now on data_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_data_out   <= FILL_BYTE;
         r_data_valid <= 1'b0;
         r_slot_idx   <= '0;
         r_slot_ptr   <= '0;
         r_underrun   <= '0;
      end else begin
         r_data_out   <= FILL_BYTE;
         r_data_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (en) begin
                  r_state <= PRIME;
               end
            end
            PRIME: begin
               if (!en) begin
                  r_state <= IDLE;
               end else if (w_primed) begin
                  r_state <= STREAM;
               end
            end
            STREAM: begin
               if (!en) begin
                  r_state <= IDLE;
               end else begin
                  r_slot_idx <= r_slot_ptr;
                  r_slot_ptr <= r_slot_ptr + SLOT_W'(1);
                  if (!w_empty) begin
                     r_data_out   <= w_head;
                     r_data_valid <= 1'b1;
                  end else begin
                     r_underrun <= sat_inc(r_underrun);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign data_out     = r_data_out;
   assign data_valid   = r_data_valid;
   assign slot_idx     = r_slot_idx;
   assign level        = w_level;
   assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_byte_stream_feeder.sv
// Scoreboard bench for byte_stream_feeder: a queue-based reference model predicts every
// emitted byte and its ring slot; a negedge monitor consumes predictions as bytes appear.
module tb_byte_stream_feeder;

   localparam int unsigned DEPTH     = 8;
   localparam int unsigned PRIME_LVL = 4;
   localparam logic [7:0]  FILL      = 8'h00;

   typedef struct {
      logic [7:0] d;
      logic [3:0] s;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic [7:0] data_out;
   logic       data_valid;
   logic [3:0] slot_idx;
   logic [4:0] level;
   logic [7:0] underrun_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: queue contents, mode (0 idle, 1 prime, 2 stream), counts.
   logic [7:0] q[$];
   sb_t        sb[$];
   int         m_mode = 0;
   int         m_nstream = 0;
   int         m_unr = 0;
   bit         m_dv = 0;
   bit         m_acc = 0;

   byte_stream_feeder #(
      .DEPTH     (DEPTH),
      .PRIME_LVL (PRIME_LVL),
      .FILL_BYTE (FILL)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .data_out     (data_out),
      .data_valid   (data_valid),
      .slot_idx     (slot_idx),
      .level        (level),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic int exp_slot();
      return (m_nstream == 0) ? 0 : (m_nstream - 1) % 16;
   endfunction

   // One clock edge of the specification's behaviour, applied to the model.
   task automatic model_step();
      sb_t e;
      m_acc = in_valid && (q.size() < DEPTH);
      m_dv  = 1'b0;
      case (m_mode)
         0: if (en) m_mode = 1;
         1: begin
            if (!en) m_mode = 0;
            else if (q.size() >= PRIME_LVL) m_mode = 2;
         end
         default: begin
            if (!en) m_mode = 0;
            else begin
               m_nstream++;
               if (q.size() != 0) begin
                  e.d = q.pop_front();
                  e.s = 4'(exp_slot());
                  sb.push_back(e);
                  m_dv = 1'b1;
               end else if (m_unr < 255) begin
                  m_unr++;
               end
            end
         end
      endcase
      if (m_acc) q.push_back(in_data);
   endtask

   task automatic model_reset();
      q.delete();
      sb.delete();
      m_mode = 0;
      m_nstream = 0;
      m_unr = 0;
      m_dv = 0;
      m_acc = 0;
   endtask

   task automatic cyc(input bit e, input bit v, input logic [7:0] d);
      @(negedge clk);
      en = e;
      in_valid = v;
      in_data = d;
      #1;
      chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
      @(posedge clk);
      model_step();
      #1;
      chk("data_valid", 32'(data_valid), 32'(m_dv));
      chk("level", 32'(level), 32'(q.size()));
      chk("underrun_cnt", 32'(underrun_cnt), 32'(m_unr));
      chk("slot_idx", 32'(slot_idx), 32'(exp_slot()));
      if (!m_dv) chk("fill_byte", 32'(data_out), 32'(FILL));
   endtask

   // Hold a byte on the interface until the model says it was accepted.
   task automatic push_hold(input bit e, input logic [7:0] d);
      int n = 0;
      do begin
         cyc(e, 1'b1, d);
         n++;
      end while (!m_acc && n < 50);
      if (!m_acc) begin
         n_vec++;
         n_err++;
         $display("FAIL push_timeout: byte %0h not accepted after %0d cycles", d, n);
      end
   endtask

   // Monitor: every real byte must match the oldest outstanding prediction.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n && data_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_byte @%0t: got %0h at slot %0d, none predicted",
                     $time, data_out, slot_idx);
         end else begin
            e = sb.pop_front();
            chk("sb_data", 32'(data_out), 32'(e.d));
            chk("sb_slot", 32'(slot_idx), 32'(e.s));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pend;
      bit         have;
      pend = 8'h00;
      have = 1'b0;

      #2;
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'(FILL));
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_slot", 32'(slot_idx), 32'd0);
      #10 rst_n = 1'b1;

      // Idle after reset.
      repeat (10) cyc(1'b0, 1'b0, 8'h00);

      // Prime with 10..13, stream them, then three underruns.
      cyc(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'h10 + i));
      repeat (8) cyc(1'b1, 1'b0, 8'h00);
      chk("underrun_after_drain", 32'(underrun_cnt), 32'd3);
      chk("slot_after_drain", 32'(slot_idx), 32'd6);

      // Fill to full while idle; A8 must wait and then follow A7.
      cyc(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) push_hold(1'b0, 8'(8'hA0 + i));
      chk("full_level", 32'(level), 32'(DEPTH));
      repeat (3) cyc(1'b0, 1'b1, 8'hA8);
      push_hold(1'b1, 8'hA8);
      repeat (12) cyc(1'b1, 1'b0, 8'h00);

      // Steady state: five bytes buffered, one in and one out per cycle.
      cyc(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 5; i++) push_hold(1'b0, 8'(8'h50 + i));
      repeat (2) cyc(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b1, 8'($urandom));
         chk("steady_level", 32'(level), 32'd5);
      end

      // Long underrun saturates the counter.
      repeat (280) cyc(1'b1, 1'b0, 8'h00);
      chk("underrun_sat", 32'(underrun_cnt), 32'd255);

      // Asynchronous reset mid-stream, away from any clock edge.
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_data_valid", 32'(data_valid), 32'd0);
      chk("async_level", 32'(level), 32'd0);
      chk("async_slot", 32'(slot_idx), 32'd0);
      chk("async_underrun", 32'(underrun_cnt), 32'd0);
      chk("async_data_out", 32'(data_out), 32'(FILL));
      model_reset();
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) cyc(1'b1, 1'b0, 8'h00);

      // Randomized valid/ready source with occasional enable drops.
      for (int i = 0; i < 1500; i++) begin
         bit e;
         e = ($urandom_range(0, 19) != 0);
         if (!have) begin
            have = ($urandom_range(0, 2) != 0);
            pend = 8'($urandom);
         end
         cyc(e, have, pend);
         if (have && m_acc) have = 1'b0;
      end

      repeat (2) cyc(1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
